// File: rtl/alu_psr_pipe.sv
// Two-stage ALU (operand register S1, result register S2) with a 5-bit
// program status register {F,L,C,N,Z} that each op updates through a per-op mask.
module alu_psr_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_flcnz,
  output logic [4:0]       psr_flcnz,
  input  logic             psr_wr_en,
  input  logic [4:0]       psr_wr_data
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_PASS = 4'd9
  } op_e;

  localparam logic [4:0] MASK_ARITH = 5'b10101;  // F, C, Z
  localparam logic [4:0] MASK_CMP   = 5'b01011;  // L, N, Z
  localparam logic [4:0] MASK_LOGIC = 5'b00001;  // Z

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s2_valid;
  logic [4:0]       psr;

  logic             s2_adv;
  logic             s1_xfer;
  logic             in_fire;

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_fl;
  logic [4:0]       alu_mask;

  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_xfer  = s1_valid & s2_adv;
  // Gating with RESETn keeps requests out while reset is asserted.
  assign in_ready = RESETn & (~s1_valid | s2_adv);
  assign in_fire  = in_valid & in_ready;

  assign out_valid = s2_valid;
  assign psr_flcnz = psr;

  // Subtract-type ops add the inverted b; the carry-in supplies the +1 or PSR.C.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    b_eff    = s1_b;
    cin      = 1'b0;
    alu_res  = '0;
    alu_fl   = '0;
    alu_mask = '0;

    case (s1_op)
      OP_SUB, OP_CMP: begin b_eff = ~s1_b; cin = 1'b1;   end
      OP_SUBC:        begin b_eff = ~s1_b; cin = psr[2]; end
      OP_ADDC:        cin = psr[2];
      default:        ;
    endcase

    sum = {1'b0, s1_a} + {1'b0, b_eff} + (WIDTH+1)'(cin);
    ovf = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != s1_a[WIDTH-1]);

    case (s1_op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
        alu_res  = sum[WIDTH-1:0];
        alu_fl   = {ovf, 1'b0, sum[WIDTH], 1'b0, sum[WIDTH-1:0] == '0};
        alu_mask = MASK_ARITH;
      end
      OP_CMP: begin
        alu_fl   = {1'b0, ~sum[WIDTH], 1'b0, $signed(s1_a) < $signed(s1_b), s1_a == s1_b};
        alu_mask = MASK_CMP;
      end
      OP_AND:  begin alu_res = s1_a & s1_b; alu_mask = MASK_LOGIC; end
      OP_OR:   begin alu_res = s1_a | s1_b; alu_mask = MASK_LOGIC; end
      OP_XOR:  begin alu_res = s1_a ^ s1_b; alu_mask = MASK_LOGIC; end
      OP_NOT:  begin alu_res = ~s1_a;       alu_mask = MASK_LOGIC; end
      OP_PASS: begin alu_res = s1_b;        alu_mask = MASK_LOGIC; end
      default: ;
    endcase

    if (alu_mask == MASK_LOGIC) alu_fl = {4'b0000, alu_res == '0};
  end

  // NOTE: operand registers are qualified by s1_valid, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (in_fire) begin
      s1_a  <= in_a;
      s1_b  <= in_b;
      s1_op <= op_e'(in_op);
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_flcnz  <= '0;
      psr        <= '0;
    end else begin
      if (in_fire)     s1_valid <= 1'b1;
      else if (s2_adv) s1_valid <= 1'b0;

      if (s2_adv) s2_valid <= s1_valid;
      if (s1_xfer) begin
        out_result <= alu_res;
        out_flcnz  <= alu_fl;
      end

      // A direct load overrides the whole PSR, including a same-cycle op update.
      if (psr_wr_en)    psr <= psr_wr_data;
      else if (s1_xfer) psr <= (psr & ~alu_mask) | (alu_fl & alu_mask);
    end
  end

endmodule
